// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone bus constants and helpers for the arbiter and its fabric peers.
// Field widths are fixed by the bus; clog2 sizes grant and watchdog registers.
package wb_arbiter_pkg;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_SW   = 4;
    localparam int WB_CTIW = 3;
    localparam int WB_BTEW = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_priority.sv
// Combinational round-robin picker: first requester after `last`, wrapping modulo N.
module rr_priority #(
    parameter int N  = 2,
    parameter int GW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic [GW-1:0] sel,
    output logic          valid
);

    logic [GW-1:0] idx;

    // Scan from the farthest candidate back to last+1 so the nearest hit is written last and wins.
    always_comb begin
        sel   = last;
        valid = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = GW'((int'(last) + k) % N);
            if (req[idx]) begin
                sel   = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// N-to-1 Wishbone B4 arbiter: grant held for a whole cyc tenure, round-robin between tenures,
// optional watchdog that terminates a silent slave with a one-cycle err.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NMASTERS = 2,
    parameter int TIMEOUT  = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NMASTERS*WB_AW-1:0]     master_addr,
    input  logic [NMASTERS*WB_DW-1:0]     master_wdata,
    input  logic [NMASTERS*WB_SW-1:0]     master_sel,
    input  logic [NMASTERS-1:0]           master_we,
    input  logic [NMASTERS-1:0]           master_cyc,
    input  logic [NMASTERS-1:0]           master_stb,
    input  logic [NMASTERS*WB_CTIW-1:0]   master_cti,
    input  logic [NMASTERS*WB_BTEW-1:0]   master_bte,
    output logic [WB_DW-1:0]              master_rdata,
    output logic [NMASTERS-1:0]           master_ack,
    output logic [NMASTERS-1:0]           master_err,
    output logic [WB_AW-1:0]              slave_addr,
    output logic [WB_DW-1:0]              slave_wdata,
    output logic [WB_SW-1:0]              slave_sel,
    output logic                          slave_we,
    output logic                          slave_cyc,
    output logic                          slave_stb,
    output logic [WB_CTIW-1:0]            slave_cti,
    output logic [WB_BTEW-1:0]            slave_bte,
    input  logic [WB_DW-1:0]              slave_rdata,
    input  logic                          slave_ack,
    input  logic                          slave_err
);

    localparam int GW = (clog2(NMASTERS) < 1) ? 1 : clog2(NMASTERS);

    arb_state_e    state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] last_q;
    logic [GW-1:0] pick;
    logic          pick_vld;
    logic          busy;
    logic          tmo_err;

    rr_priority #(
        .N  (NMASTERS),
        .GW (GW)
    ) u_rr (
        .req   (master_cyc),
        .last  (last_q),
        .sel   (pick),
        .valid (pick_vld)
    );

    assign busy         = (state_q == ST_BUSY);
    assign master_rdata = slave_rdata;

    // cyc/stb gated by BUSY so an asynchronous reset drops them without waiting for a clock.
    always_comb begin
        slave_addr  = master_addr [int'(grant_q)*WB_AW   +: WB_AW];
        slave_wdata = master_wdata[int'(grant_q)*WB_DW   +: WB_DW];
        slave_sel   = master_sel  [int'(grant_q)*WB_SW   +: WB_SW];
        slave_cti   = master_cti  [int'(grant_q)*WB_CTIW +: WB_CTIW];
        slave_bte   = master_bte  [int'(grant_q)*WB_BTEW +: WB_BTEW];
        slave_we    = master_we[grant_q];
        slave_cyc   = busy & master_cyc[grant_q];
        slave_stb   = busy & master_stb[grant_q];
    end

    always_comb begin
        master_ack = '0;
        master_err = '0;
        if (busy) begin
            master_ack[grant_q] = slave_ack;
            master_err[grant_q] = slave_err | tmo_err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NMASTERS - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!master_cyc[grant_q]) begin
                        last_q  <= grant_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int CW = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT);

            logic [CW-1:0] tmo_cnt_q;
            logic [CW-1:0] tmo_cnt_d;
            logic          slave_silent;
            logic          hit;

            // slave_cyc is already low in IDLE, so this also clears the count between tenures.
            assign slave_silent = slave_cyc & slave_stb & ~slave_ack & ~slave_err;
            assign hit          = slave_silent && (tmo_cnt_q == CW'(TIMEOUT - 1));
            assign tmo_err      = hit;

            always_comb begin
                tmo_cnt_d = tmo_cnt_q + CW'(1);
                if (!slave_silent || hit) tmo_cnt_d = '0;
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) tmo_cnt_q <= '0;
                else       tmo_cnt_q <= tmo_cnt_d;
            end
        end else begin : g_no_wdog
            assign tmo_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed tenures push expected grants/responses,
// negedge monitors pop and compare whenever the arbiters present them.
module tb_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    int           cyc_cnt = 0;
    int           tests = 0;
    int           fails = 0;

    // Two-master stimulus shared by DUT A (TIMEOUT=16) and DUT B (TIMEOUT=0)
    logic [63:0]  m_addr, m_wdata;
    logic [7:0]   m_sel;
    logic [1:0]   m_we, m_cyc, m_stb;
    logic [5:0]   m_cti;
    logic [3:0]   m_bte;
    logic [31:0]  s_rdata;
    logic         s_ack, s_err;

    logic [31:0]  a_rdata, a_s_addr, a_s_wdata, b_rdata, b_s_addr, b_s_wdata;
    logic [1:0]   a_ack, a_err, b_ack, b_err, a_s_bte, b_s_bte;
    logic [3:0]   a_s_sel, b_s_sel;
    logic [2:0]   a_s_cti, b_s_cti;
    logic         a_s_we, a_s_cyc, a_s_stb, b_s_we, b_s_cyc, b_s_stb;

    // Four-master DUT C with a zero-wait slave
    logic [127:0] mc_addr, mc_wdata;
    logic [15:0]  mc_sel;
    logic [3:0]   mc_we, mc_cyc, mc_stb;
    logic [11:0]  mc_cti;
    logic [7:0]   mc_bte;
    logic [31:0]  c_rdata, c_s_addr, c_s_wdata;
    logic [3:0]   c_ack, c_err, c_s_sel;
    logic [2:0]   c_s_cti;
    logic [1:0]   c_s_bte;
    logic         c_s_we, c_s_cyc, c_s_stb, c_s_ack;
    logic         c_s_err = 1'b0;

    assign c_s_ack = c_s_cyc & c_s_stb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_arbiter #(.NMASTERS(2), .TIMEOUT(16)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .master_addr(m_addr), .master_wdata(m_wdata), .master_sel(m_sel), .master_we(m_we),
        .master_cyc(m_cyc), .master_stb(m_stb), .master_cti(m_cti), .master_bte(m_bte),
        .master_rdata(a_rdata), .master_ack(a_ack), .master_err(a_err),
        .slave_addr(a_s_addr), .slave_wdata(a_s_wdata), .slave_sel(a_s_sel), .slave_we(a_s_we),
        .slave_cyc(a_s_cyc), .slave_stb(a_s_stb), .slave_cti(a_s_cti), .slave_bte(a_s_bte),
        .slave_rdata(s_rdata), .slave_ack(s_ack), .slave_err(s_err)
    );

    wb_arbiter #(.NMASTERS(2), .TIMEOUT(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .master_addr(m_addr), .master_wdata(m_wdata), .master_sel(m_sel), .master_we(m_we),
        .master_cyc(m_cyc), .master_stb(m_stb), .master_cti(m_cti), .master_bte(m_bte),
        .master_rdata(b_rdata), .master_ack(b_ack), .master_err(b_err),
        .slave_addr(b_s_addr), .slave_wdata(b_s_wdata), .slave_sel(b_s_sel), .slave_we(b_s_we),
        .slave_cyc(b_s_cyc), .slave_stb(b_s_stb), .slave_cti(b_s_cti), .slave_bte(b_s_bte),
        .slave_rdata(s_rdata), .slave_ack(s_ack), .slave_err(s_err)
    );

    wb_arbiter #(.NMASTERS(4), .TIMEOUT(0)) u_dut_c (
        .clk_i(clk), .rst_i(rst),
        .master_addr(mc_addr), .master_wdata(mc_wdata), .master_sel(mc_sel), .master_we(mc_we),
        .master_cyc(mc_cyc), .master_stb(mc_stb), .master_cti(mc_cti), .master_bte(mc_bte),
        .master_rdata(c_rdata), .master_ack(c_ack), .master_err(c_err),
        .slave_addr(c_s_addr), .slave_wdata(c_s_wdata), .slave_sel(c_s_sel), .slave_we(c_s_we),
        .slave_cyc(c_s_cyc), .slave_stb(c_s_stb), .slave_cti(c_s_cti), .slave_bte(c_s_bte),
        .slave_rdata(32'h0), .slave_ack(c_s_ack), .slave_err(c_s_err)
    );

    typedef struct {
        bit          is_resp;
        logic [31:0] val;     // grant: slave_addr; response: {err, ack}
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        qa[$];
    logic [31:0] qc[$];
    int          b_err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event 0x%0h at cycle %0d, nothing expected", name, act, cyc_cnt);
    endtask

    task automatic exp_grant(input logic [31:0] addr, input int cyc);
        exp_t e;
        e.is_resp = 1'b0; e.val = addr; e.rdata = '0; e.cyc = cyc;
        qa.push_back(e);
    endtask

    task automatic exp_resp(input logic [1:0] err, input logic [1:0] ack, input logic [31:0] rd, input int cyc);
        exp_t e;
        e.is_resp = 1'b1; e.val = {28'h0, err, ack}; e.rdata = rd; e.cyc = cyc;
        qa.push_back(e);
    endtask

    // Monitors: sample mid-cycle, well away from the active edge
    logic a_prev_cyc = 1'b0;
    logic c_prev_cyc = 1'b0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_s_cyc && !a_prev_cyc) begin
            if (qa.size() == 0) unexpected("a_grant", a_s_addr);
            else begin
                e = qa.pop_front();
                chk("a_grant_kind", 32'(e.is_resp), 32'(0));
                chk("a_grant_addr", a_s_addr, e.val);
                chk("a_grant_cycle", 32'(cyc_cnt), 32'(e.cyc));
            end
        end
        if (|a_ack || |a_err) begin
            if (qa.size() == 0) unexpected("a_resp", {28'h0, a_err, a_ack});
            else begin
                e = qa.pop_front();
                chk("a_resp_kind", 32'(e.is_resp), 32'(1));
                chk("a_resp_err_ack", {28'h0, a_err, a_ack}, e.val);
                chk("a_resp_rdata", a_rdata, e.rdata);
                chk("a_resp_cycle", 32'(cyc_cnt), 32'(e.cyc));
            end
        end
        a_prev_cyc = a_s_cyc;
    end

    always @(negedge clk) begin : mon_bc
        if (|b_err) b_err_cnt++;
        if (c_s_cyc && !c_prev_cyc) begin
            if (qc.size() == 0) unexpected("c_grant", c_s_addr);
            else chk("c_grant_addr", c_s_addr, qc.pop_front());
        end
        c_prev_cyc = c_s_cyc;
    end

    // Slave for DUT A/B: acks sl_delay cycles after stb is first seen; silent when sl_en=0
    int          sl_delay = 1;
    bit          sl_en    = 1'b1;
    logic [31:0] sl_rdata = 32'h0;

    initial begin : slave_model
        int wcnt;
        bit nxt;
        wcnt = 0; s_ack = 1'b0; s_err = 1'b0; s_rdata = '0;
        forever begin
            @(negedge clk);
            if (sl_en && a_s_cyc && a_s_stb && !s_ack) begin
                wcnt++;
                nxt = (wcnt >= sl_delay);
            end else begin
                wcnt = 0;
                nxt  = 1'b0;
            end
            @(posedge clk);
            #1;
            s_ack   = nxt;
            s_rdata = sl_rdata;
        end
    end

    // One master tenure on DUT A/B; called at posedge+1, returns at posedge+1 of the cycle cyc drops
    task automatic m_run(input int i, input logic [31:0] addr, input int beats);
        m_addr[i*32 +: 32] = addr;
        m_cti[i*3 +: 3]    = (beats > 1) ? 3'b010 : 3'b000;
        m_cyc[i] = 1'b1;
        m_stb[i] = 1'b1;
        for (int b = 0; b < beats; b++) begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(a_ack[i] || a_err[i]) && n < 200);
            tests++;
            if (!(a_ack[i] || a_err[i])) begin
                fails++;
                $display("FAIL m%0d_wait: no ack/err within %0d cycles", i, n);
            end
            @(posedge clk);
            #1;
            if (b < beats - 1) begin
                addr = addr + 32'd4;
                m_addr[i*32 +: 32] = addr;
                if (b == beats - 2) m_cti[i*3 +: 3] = 3'b111;
            end
        end
        m_cyc[i] = 1'b0;
        m_stb[i] = 1'b0;
        m_cti[i*3 +: 3] = 3'b000;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3; rst = 1'b1;
        @(posedge clk); #3; rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #60000;
        $display("FAIL global_timeout: bench did not complete, %0d tests run", tests);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int t0;
        int k;
        int n;
        rst     = 1'b0;
        m_addr  = {32'h0000_0200, 32'h0000_0100};
        m_wdata = {32'h2222_2222, 32'h1111_1111};
        m_sel   = 8'h3F;
        m_we    = 2'b10;
        m_cyc   = 2'b00;
        m_stb   = 2'b00;
        m_cti   = '0;
        m_bte   = '0;
        mc_addr  = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
        mc_wdata = '0;
        mc_sel   = '1;
        mc_we    = '0;
        mc_cyc   = '0;
        mc_stb   = '0;
        mc_cti   = '0;
        mc_bte   = '0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state: bus idle, passive fields show master 0
        chk("rst_slave_cyc", 32'(a_s_cyc), 32'(0));
        chk("rst_slave_stb", 32'(a_s_stb), 32'(0));
        chk("rst_ack_err", {28'h0, a_err, a_ack}, 32'h0);
        chk("rst_slave_addr", a_s_addr, 32'h100);
        chk("rst_slave_sel", 32'(a_s_sel), 32'hF);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single master read, slave acks 2 cycles after stb
        sl_delay = 2; sl_rdata = 32'hDEAD_BEEF; sl_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        t0 = cyc_cnt;
        exp_grant(32'h100, t0 + 1);
        exp_resp(2'b00, 2'b01, 32'hDEAD_BEEF, t0 + 3);
        m_run(0, 32'h100, 1);
        repeat (2) @(posedge clk);
        #1;

        // Contention after reset: m0, then m1 two cycles after m0 drops, then back to m0
        pulse_reset();
        t0 = cyc_cnt;
        exp_grant(32'h100, t0 + 1);
        exp_resp(2'b00, 2'b01, 32'hDEAD_BEEF, t0 + 3);
        exp_grant(32'h200, t0 + 6);
        exp_resp(2'b00, 2'b10, 32'hDEAD_BEEF, t0 + 8);
        exp_grant(32'h100, t0 + 11);
        exp_resp(2'b00, 2'b01, 32'hDEAD_BEEF, t0 + 13);
        fork
            begin
                m_run(0, 32'h100, 1);
                @(posedge clk); #1;
                m_run(0, 32'h100, 1);
            end
            m_run(1, 32'h200, 1);
        join
        repeat (2) @(posedge clk);
        #1;

        // 4-beat incrementing burst by m0 while m1 waits
        sl_delay = 1; sl_rdata = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        t0 = cyc_cnt;
        exp_grant(32'h100, t0 + 1);
        for (int b = 0; b < 4; b++) exp_resp(2'b00, 2'b01, 32'hCAFE_F00D, t0 + 2 + 2*b);
        exp_grant(32'h200, t0 + 11);
        exp_resp(2'b00, 2'b10, 32'hCAFE_F00D, t0 + 12);
        fork
            m_run(0, 32'h100, 4);
            begin
                @(posedge clk); #1;
                m_run(1, 32'h200, 1);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Silent slave: watchdog err 16 cycles after stb (DUT B must stay quiet)
        sl_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        t0 = cyc_cnt;
        exp_grant(32'h100, t0 + 1);
        exp_resp(2'b01, 2'b00, 32'hCAFE_F00D, t0 + 16);
        m_run(0, 32'h100, 1);
        repeat (2) @(posedge clk);
        #1;

        // Ack lands in the very cycle the watchdog would fire: ack wins, no err
        sl_en = 1'b1; sl_delay = 15;
        repeat (2) @(posedge clk);
        #1;
        t0 = cyc_cnt;
        exp_grant(32'h100, t0 + 1);
        exp_resp(2'b00, 2'b01, 32'hCAFE_F00D, t0 + 16);
        m_run(0, 32'h100, 1);
        repeat (2) @(posedge clk);
        #1;

        // Async reset mid-burst; last was m0, so only a reset last lets m0 win the next contention
        sl_delay = 1;
        t0 = cyc_cnt;
        exp_grant(32'h100, t0 + 1);
        m_cti[2:0] = 3'b010;
        m_cyc[0]   = 1'b1;
        m_stb[0]   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_slave_cyc", 32'(a_s_cyc), 32'(1));
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_slave_cyc", 32'(a_s_cyc), 32'(0));
        chk("async_rst_slave_stb", 32'(a_s_stb), 32'(0));
        m_cyc = 2'b00;
        m_stb = 2'b00;
        m_cti = '0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        t0 = cyc_cnt;
        exp_grant(32'h100, t0 + 1);
        exp_resp(2'b00, 2'b01, 32'hCAFE_F00D, t0 + 2);
        exp_grant(32'h200, t0 + 5);
        exp_resp(2'b00, 2'b10, 32'hCAFE_F00D, t0 + 6);
        fork
            m_run(0, 32'h100, 1);
            m_run(1, 32'h200, 1);
        join
        repeat (2) @(posedge clk);
        #1;

        // Four masters requesting continuously, one-beat tenures: 0,1,2,3,0
        qc.push_back(32'h1000);
        qc.push_back(32'h2000);
        qc.push_back(32'h3000);
        qc.push_back(32'h4000);
        qc.push_back(32'h1000);
        mc_cyc = 4'hF;
        mc_stb = 4'hF;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (c_ack == 4'h0 && n < 50);
            tests++;
            if (c_ack == 4'h0) begin
                fails++;
                $display("FAIL c_wait: no ack within %0d cycles on grant %0d", n, g);
            end
            k = 0;
            for (int j = 0; j < 4; j++) if (c_ack[j]) k = j;
            @(posedge clk); #1;
            mc_cyc[k] = 1'b0;
            mc_stb[k] = 1'b0;
            if (g == 4) begin
                mc_cyc = 4'h0;
                mc_stb = 4'h0;
            end else begin
                @(posedge clk); #1;
                mc_cyc[k] = 1'b1;
                mc_stb[k] = 1'b1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("qa_drained", 32'(qa.size()), 32'(0));
        chk("qc_drained", 32'(qc.size()), 32'(0));
        chk("b_no_err", 32'(b_err_cnt), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
